// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one input bit per clock) feeding the display driver.
// Optional build macro DISP_SATURATE_EN: out-of-range inputs show all nines instead of value mod 10^DIGITS.
module bcd_convert_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   number,
    output logic                  on,
    output logic                  done,
    output logic                  ovf
);

    localparam int          NUM_W   = 4 * DIGITS;
    localparam int          SW      = NUM_W + BIN_W;
    localparam int          CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      scratch;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               accept;

    // One double-dabble step: correct every BCD nibble, then shift the whole scratch left.
    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[BIN_W + 4*d +: 4] >= 4'd5)
                r[BIN_W + 4*d +: 4] = r[BIN_W + 4*d +: 4] + 4'd3;
        end
        return {r[SW-2:0], 1'b0};
    endfunction

`ifdef DISP_SATURATE_EN
    function automatic logic [NUM_W-1:0] saturate(input logic [NUM_W-1:0] acc,
                                                  input logic            over);
        return over ? {DIGITS{4'h9}} : acc;
    endfunction
`endif

    assign accept = in_valid && (state_q == IDLE) && !clear;

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE);
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid) state_d = SHIFT;
                SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_d = LOAD;
                LOAD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            number   <= '0;
            on       <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            cnt      <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (clear) begin
                number <= '0;
                on     <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            scratch  <= {{NUM_W{1'b0}}, bin_in};
                            cnt      <= '0;
                            ovf      <= 1'b0;
                            ovf_pend <= (32'(bin_in) > MAX_VAL);
                        end
                    end
                    SHIFT: begin
                        scratch <= dabble(scratch);
                        cnt     <= cnt + CNT_W'(1);
                    end
                    LOAD: begin
                        // Upper digits beyond DIGITS were shifted out, leaving value mod 10^DIGITS.
`ifdef DISP_SATURATE_EN
                        number <= saturate(scratch[SW-1 -: NUM_W], ovf_pend);
`else
                        number <= scratch[SW-1 -: NUM_W];
`endif
                        on   <= 1'b1;
                        done <= 1'b1;
                        ovf  <= ovf_pend;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed self-checking bench for bcd_convert_seq: reset, conversions, back-to-back, overflow, clear/reset abort.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid;
    logic [13:0] bin_in;
    logic        in_ready, on, done, ovf;
    logic [15:0] number;

    int vectors = 0;
    int errors  = 0;

    bcd_convert_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bin_in(bin_in), .in_valid(in_valid),
        .in_ready(in_ready), .number(number), .on(on), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full conversion from IDLE with fixed latency of 15 edges after the accept edge.
    task automatic convert(input logic [13:0] v, input logic [15:0] expn, input logic expovf,
                           input logic [15:0] prevn);
        bin_in   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
        check("ovf_cleared_on_accept", ovf, 0);
        repeat (14) step();
        check("no_early_done", done, 0);
        check("number_held", number, prevn);
        step();
        check("number", number, expn);
        check("done_pulse", done, 1);
        check("on", on, 1);
        check("ovf", ovf, expovf);
        check("ready_back", in_ready, 1);
        step();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic saw_done;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; bin_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_number", number, 16'h0000);
        check("rst_on", on, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);

        convert(14'd1234, 16'h1234, 1'b0, 16'h0000);

        // Back-to-back with in_valid held high; bin_in changes while busy and must be ignored.
        bin_in   = 14'd9999;
        in_valid = 1'b1;
        step();
        check("b2b_busy", in_ready, 0);
        bin_in = 14'd0;
        repeat (14) step();
        check("b2b_no_done", done, 0);
        step();
        check("b2b_first", number, 16'h9999);
        check("b2b_first_done", done, 1);
        check("b2b_ready", in_ready, 1);
        step();
        check("b2b_second_accepted", in_ready, 0);
        repeat (14) step();
        check("b2b_spacing", done, 0);
        check("b2b_hold", number, 16'h9999);
        step();
        in_valid = 1'b0;
        check("b2b_second", number, 16'h0000);
        check("b2b_second_done", done, 1);
        check("zero_on", on, 1);
        step();

`ifdef DISP_SATURATE_EN
        convert(14'd12345, 16'h9999, 1'b1, 16'h0000);
`else
        convert(14'd12345, 16'h2345, 1'b1, 16'h0000);
`endif
        check("ovf_sticky", ovf, 1);
`ifdef DISP_SATURATE_EN
        convert(14'd1234, 16'h1234, 1'b0, 16'h9999);
`else
        convert(14'd1234, 16'h1234, 1'b0, 16'h2345);
`endif

        // Abort by clear mid-conversion.
        bin_in   = 14'd4321;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ready", in_ready, 1);
        check("clr_number", number, 16'h0000);
        check("clr_on", on, 0);
        check("clr_done", done, 0);
        saw_done = 1'b0;
        repeat (16) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("clr_no_done", saw_done, 0);
        check("clr_number_after", number, 16'h0000);

        // Abort by reset mid-conversion.
        convert(14'd57, 16'h0057, 1'b0, 16'h0000);
        bin_in   = 14'd4321;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_ready", in_ready, 1);
        check("rst2_number", number, 16'h0000);
        check("rst2_on", on, 0);
        saw_done = 1'b0;
        repeat (16) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("rst2_no_done", saw_done, 0);

        // clear wins over in_valid in IDLE.
        bin_in   = 14'd77;
        in_valid = 1'b1;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_valid_not_accepted", in_ready, 1);
        check("clr_valid_number", number, 16'h0000);
        saw_done = 1'b0;
        repeat (16) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("clr_valid_no_done", saw_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
